// File: rtl/tff_pkg.sv
// Shared definitions for the T flip-flop counter family.
//   DIR_UP / DIR_DOWN  : direction encodings for the 'up' input
//   tff_toggle_mask()  : ripple toggle vector for one count step in a given direction
//   tff_clamp()        : limits a load value to the counter's modulus range
// Build option: TFF_COUNTER_SAT_EN (consumed by t_ff_counter, not by this package).
package tff_pkg;

  // Widest counter the helper functions support; callers zero-extend and truncate.
  localparam int unsigned TFF_MAX_W = 32;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef logic [TFF_MAX_W-1:0] tff_word_t;

  // Counting up, bit i toggles when every lower bit is 1; counting down,
  // when every lower bit is 0. Bit 0 always toggles.
  function automatic tff_word_t tff_toggle_mask(input tff_word_t q, input logic dir);
    tff_word_t m;
    m    = '0;
    m[0] = 1'b1;
    for (int i = 1; i < int'(TFF_MAX_W); i++) begin
      m[i] = m[i-1] & ((dir == DIR_UP) ? q[i-1] : ~q[i-1]);
    end
    return m;
  endfunction

  // Returns min(val, modulus-1).
  function automatic tff_word_t tff_clamp(input tff_word_t val, input tff_word_t modulus);
    return (val >= modulus) ? (modulus - tff_word_t'(1)) : val;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single-bit positive-edge T flip-flop with asynchronous active-low reset to 0.
//   clk : clock
//   rst : asynchronous reset, active-low
//   t   : toggle request, sampled on the rising edge
//   q   : stored bit
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else      q <= q ^ t;
  end

endmodule

// File: rtl/t_ff_counter.sv
// Up/down modulo-N counter built from a bank of T flip-flops. The only path
// into the state bits is the toggle vector t_vec (q_next = q ^ t_vec).
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active-low
//   en       : count enable, one step per cycle
//   up       : direction, 1 = increment, 0 = decrement
//   load     : synchronous load strobe (overrides en/up)
//   load_val : value captured on load, clamped to MODULUS-1
//   q        : current count (registered)
//   tc       : terminal count, combinational: en & (q at the bound in the count direction)
//   wrap     : registered pulse, high the cycle after a wrap (or saturate) event
// Build option: define TFF_COUNTER_SAT_EN for saturating mode (hold at the
// bound; wrap pulses once per stay at the bound). Default is modulo wrap.
module t_ff_counter
  import tff_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] load_tgt;
  logic             at_bound;
  logic             wrap_evt;

  // Terminal-count detection in the current direction.
  always_comb begin
    at_bound = (up == DIR_UP) ? (q == Q_MAX) : (q == '0);
    tc       = en & at_bound;
  end

  assign load_tgt = WIDTH'(tff_clamp(tff_word_t'(load_val), tff_word_t'(MODULUS)));

  // Toggle-vector generation: load > count > hold.
  always_comb begin
    t_vec    = '0;
    wrap_evt = 1'b0;
    if (load) begin
      t_vec = q ^ load_tgt;
    end else if (en) begin
      if (at_bound) begin
        wrap_evt = 1'b1;
`ifdef TFF_COUNTER_SAT_EN
        t_vec = '0;
`else
        // Up: q == MAX -> 0 (toggle every set bit). Down: 0 -> MAX.
        t_vec = (up == DIR_UP) ? q : Q_MAX;
`endif
      end else begin
        t_vec = WIDTH'(tff_toggle_mask(tff_word_t'(q), up));
      end
    end
  end

  // State bits.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t_vec[i]),
      .q   (q[i])
    );
  end

`ifdef TFF_COUNTER_SAT_EN
  // 'held' remembers that the current stay at the bound already pulsed wrap;
  // it clears as soon as q moves.
  logic held;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap <= 1'b0;
      held <= 1'b0;
    end else begin
      wrap <= wrap_evt & ~held;
      held <= (held | wrap_evt) & (t_vec == '0);
    end
  end
`else
  // Wrap flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wrap <= 1'b0;
    else      wrap <= wrap_evt;
  end
`endif

endmodule

// File: tb/tb_t_ff_counter.sv
// Directed self-checking bench for t_ff_counter: a WIDTH=4/MODULUS=10 instance
// for the main scenarios, a MODULUS=16 instance and a WIDTH=1/MODULUS=2 instance
// for full-range and back-to-back wrap behaviour.
module tb_t_ff_counter;

  logic clk;
  logic rst;

  logic       en10, up10, load10;
  logic [3:0] lv10, q10;
  logic       tc10, wrap10;

  logic       en16, up16, load16;
  logic [3:0] lv16, q16;
  logic       tc16, wrap16;

  logic       en2, up2, load2;
  logic [0:0] lv2, q2;
  logic       tc2, wrap2;

  int vectors;
  int miscompares;

  t_ff_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk(clk), .rst(rst), .en(en10), .up(up10), .load(load10), .load_val(lv10),
    .q(q10), .tc(tc10), .wrap(wrap10)
  );

  t_ff_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .rst(rst), .en(en16), .up(up16), .load(load16), .load_val(lv16),
    .q(q16), .tc(tc16), .wrap(wrap16)
  );

  t_ff_counter #(.WIDTH(1), .MODULUS(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .up(up2), .load(load2), .load_val(lv2),
    .q(q2), .tc(tc2), .wrap(wrap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Short reset pulse between edges.
  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en10 = 0; up10 = 1; load10 = 0; lv10 = '0;
    en16 = 0; up16 = 1; load16 = 0; lv16 = '0;
    en2  = 0; up2  = 1; load2  = 0; lv2  = '0;
    tick(); tick();
    vectors++;
    if (q10 !== 4'd0 || wrap10 !== 1'b0 || tc10 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: q=%0d wrap=%0b tc=%0b expected q=0 wrap=0 tc=0", q10, wrap10, tc10);
    end
    rst = 1'b1;
    en10 = 1; up10 = 1;
    for (int k = 1; k <= 7; k++) tick();
    vectors++;
    if (q10 !== 4'd7) begin
      miscompares++;
      $display("FAIL reset_precount: q=%0d expected 7", q10);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (q10 !== 4'd0 || wrap10 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: q=%0d wrap=%0b expected q=0 wrap=0", q10, wrap10);
    end
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if (q10 !== 4'(k)) begin
        miscompares++;
        $display("FAIL reset_release step %0d: q=%0d expected %0d", k, q10, k);
      end
    end
    en10 = 0;
  endtask

  task automatic test_count_up();
    int exp_q;
    pulse_reset();
    en10 = 1; up10 = 1; load10 = 0;
    for (int k = 1; k <= 11; k++) begin
      tick();
`ifdef TFF_COUNTER_SAT_EN
      exp_q = (k > 9) ? 9 : k;
`else
      exp_q = k % 10;
`endif
      vectors++;
      if (q10 !== 4'(exp_q) || tc10 !== (exp_q == 9) || wrap10 !== (k == 10)) begin
        miscompares++;
        $display("FAIL count_up edge %0d: q=%0d tc=%0b wrap=%0b expected q=%0d tc=%0b wrap=%0b",
                 k, q10, tc10, wrap10, exp_q, (exp_q == 9), (k == 10));
      end
    end
    en10 = 0;
  endtask

  task automatic test_count_down();
    logic [3:0] exp_q [4];
    logic       exp_w [4];
    pulse_reset();
`ifdef TFF_COUNTER_SAT_EN
    exp_q = '{4'd0, 4'd0, 4'd1, 4'd2};
    exp_w = '{1'b1, 1'b0, 1'b0, 1'b0};
`else
    exp_q = '{4'd9, 4'd8, 4'd7, 4'd8};
    exp_w = '{1'b1, 1'b0, 1'b0, 1'b0};
`endif
    en10 = 1; up10 = 0; load10 = 0;
    for (int k = 0; k < 4; k++) begin
`ifdef TFF_COUNTER_SAT_EN
      if (k == 2) up10 = 1;
`else
      if (k == 3) up10 = 1;
`endif
      tick();
      vectors++;
      if (q10 !== exp_q[k] || wrap10 !== exp_w[k]) begin
        miscompares++;
        $display("FAIL count_down step %0d: q=%0d wrap=%0b expected q=%0d wrap=%0b",
                 k, q10, wrap10, exp_q[k], exp_w[k]);
      end
    end
    en10 = 0;
  endtask

  task automatic test_load_clamp();
    load10 = 1; lv10 = 4'd12; en10 = 1; up10 = 1;
    tick();
    vectors++;
    if (q10 !== 4'd9 || wrap10 !== 1'b0) begin
      miscompares++;
      $display("FAIL load_clamp: q=%0d wrap=%0b expected q=9 wrap=0", q10, wrap10);
    end
    load10 = 0;
    tick();
    vectors++;
`ifdef TFF_COUNTER_SAT_EN
    if (q10 !== 4'd9 || wrap10 !== 1'b1) begin
      miscompares++;
      $display("FAIL load_then_count: q=%0d wrap=%0b expected q=9 wrap=1", q10, wrap10);
    end
`else
    if (q10 !== 4'd0 || wrap10 !== 1'b1) begin
      miscompares++;
      $display("FAIL load_then_count: q=%0d wrap=%0b expected q=0 wrap=1", q10, wrap10);
    end
`endif
    en10 = 0;
  endtask

  task automatic test_hold();
    load10 = 1; lv10 = 4'd4; en10 = 0;
    tick();
    load10 = 0;
    for (int k = 0; k < 5; k++) begin
      up10 = k[0];
      tick();
      vectors++;
      if (q10 !== 4'd4 || tc10 !== 1'b0 || wrap10 !== 1'b0) begin
        miscompares++;
        $display("FAIL hold step %0d: q=%0d tc=%0b wrap=%0b expected q=4 tc=0 wrap=0",
                 k, q10, tc10, wrap10);
      end
    end
  endtask

  task automatic test_mod16();
    load16 = 1; lv16 = 4'd14; en16 = 0;
    tick();
    load16 = 0; en16 = 1; up16 = 1;
    tick();
    vectors++;
    if (q16 !== 4'd15 || tc16 !== 1'b1 || wrap16 !== 1'b0) begin
      miscompares++;
      $display("FAIL mod16_top: q=%0d tc=%0b wrap=%0b expected q=15 tc=1 wrap=0", q16, tc16, wrap16);
    end
    tick();
    vectors++;
`ifdef TFF_COUNTER_SAT_EN
    if (q16 !== 4'd15 || wrap16 !== 1'b1) begin
      miscompares++;
      $display("FAIL mod16_wrap: q=%0d wrap=%0b expected q=15 wrap=1", q16, wrap16);
    end
`else
    if (q16 !== 4'd0 || wrap16 !== 1'b1) begin
      miscompares++;
      $display("FAIL mod16_wrap: q=%0d wrap=%0b expected q=0 wrap=1", q16, wrap16);
    end
`endif
    en16 = 0;
  endtask

  // Alternating direction on MODULUS=2 forces a wrap on every edge.
  task automatic test_back_to_back();
    logic [0:0] exp_q [4];
    logic       exp_w [4];
    load2 = 1; lv2 = 1'b0; en2 = 0;
    tick();
    load2 = 0; en2 = 1;
`ifdef TFF_COUNTER_SAT_EN
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_w = '{1'b1, 1'b0, 1'b0, 1'b0};
`else
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_w = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int k = 0; k < 4; k++) begin
`ifdef TFF_COUNTER_SAT_EN
      up2 = k[0];
`else
      up2 = k[0];
`endif
      tick();
      vectors++;
      if (q2 !== exp_q[k] || wrap2 !== exp_w[k]) begin
        miscompares++;
        $display("FAIL back_to_back step %0d: q=%0d wrap=%0b expected q=%0d wrap=%0b",
                 k, q2, wrap2, exp_q[k], exp_w[k]);
      end
    end
    en2 = 0;
  endtask

`ifdef TFF_COUNTER_SAT_EN
  task automatic test_saturate();
    logic [3:0] exp_q [4];
    logic       exp_w [4];
    exp_q = '{4'd9, 4'd9, 4'd9, 4'd8};
    exp_w = '{1'b0, 1'b1, 1'b0, 1'b0};
    load10 = 1; lv10 = 4'd8; en10 = 0;
    tick();
    load10 = 0; en10 = 1; up10 = 1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) up10 = 0;
      tick();
      vectors++;
      if (q10 !== exp_q[k] || wrap10 !== exp_w[k]) begin
        miscompares++;
        $display("FAIL saturate step %0d: q=%0d wrap=%0b expected q=%0d wrap=%0b",
                 k, q10, wrap10, exp_q[k], exp_w[k]);
      end
    end
    en10 = 0;
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load_clamp();
    test_hold();
    test_mod16();
    test_back_to_back();
`ifdef TFF_COUNTER_SAT_EN
    test_saturate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
